// File: rtl/imu_uart_rx.sv
// UART byte receiver for the IMU serial link: 8 data bits LSB first, optional parity, 1 stop bit.
// Good bytes leave on a one-cycle valid strobe; corrupted bytes only raise an error strobe.
module imu_uart_rx #(
    parameter int unsigned OSC_FREQ   = 20_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx_enable,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_data_vlid,
    output logic       rx_parity_err,
    output logic       rx_frame_err
);

    localparam int unsigned CLKS_PER_BIT = OSC_FREQ / BAUD;
    localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHi
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]      idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            pbit_q, pbit_d;
    logic [7:0]      data_q, data_d;
    logic            vlid_q, vlid_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            s1_q, s2_q, s3_q;
    logic            fall;
    logic            bit_done;
    logic            parity_ok;

    // Synchronizer plus one history stage for start-edge detection; idles high.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= rx_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign fall      = s3_q & ~s2_q;
    assign bit_done  = (bit_cnt_q == BitLast);
    assign parity_ok = PARITY_EN ? ((^{shreg_q, pbit_q}) == PARITY_ODD) : 1'b1;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            pbit_q    <= 1'b0;
            data_q    <= 8'h00;
            vlid_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            pbit_q    <= pbit_d;
            data_q    <= data_d;
            vlid_q    <= vlid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + CntW'(1);
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        pbit_d    = pbit_q;
        data_d    = data_q;
        vlid_d    = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                if (fall) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                // Re-check the line at mid start bit to reject short glitches.
                if (bit_cnt_q == HalfLast) begin
                    bit_cnt_d = '0;
                    if (!s2_q) begin
                        state_d = StData;
                        idx_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (bit_done) begin
                    bit_cnt_d = '0;
                    shreg_d   = {s2_q, shreg_q[7:1]};
                    idx_d     = idx_q + 4'd1;
                    if (idx_q == 4'd7) begin
                        state_d = PARITY_EN ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (bit_done) begin
                    bit_cnt_d = '0;
                    pbit_d    = s2_q;
                    state_d   = StStop;
                end
            end
            StStop: begin
                // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
                if (bit_done) begin
                    bit_cnt_d = '0;
                    if (!s2_q) begin
                        ferr_d  = 1'b1;
                        state_d = StWaitHi;
                    end else if (parity_ok) begin
                        data_d  = shreg_q;
                        vlid_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        perr_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StWaitHi: begin
                bit_cnt_d = '0;
                if (s2_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d   = StIdle;
                bit_cnt_d = '0;
            end
        endcase

        if (!rx_enable) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            data_d    = data_q;
            vlid_d    = 1'b0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
        end
    end

    assign rx_data       = data_q;
    assign rx_data_vlid  = vlid_q;
    assign rx_parity_err = perr_q;
    assign rx_frame_err  = ferr_q;

endmodule
